// File: rtl/muldiv_pkg.sv
// Shared types, constants and operand-sign helpers for the RV32M multiply/divide unit.
// No logic of its own; imported by the interface, the iteration step and the top.
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } muldiv_state_e;

    localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] OVF_QUOT  = 32'h8000_0000;

    function automatic logic op_is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_a_signed(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_b_signed(input muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the integer pipeline (master) and the muldiv unit (slave).
// Request side is valid/ready on start_*, result side is valid/ready on res_*.
interface muldiv_if;

    logic                        start_valid;
    logic                        start_ready;
    logic [2:0]                  funct3;
    logic [muldiv_pkg::XLEN-1:0] rs1_data;
    logic [muldiv_pkg::XLEN-1:0] rs2_data;
    logic [4:0]                  rd_addr_in;
    logic                        flush;
    logic                        res_valid;
    logic                        res_ready;
    logic [muldiv_pkg::XLEN-1:0] res_data;
    logic [4:0]                  res_rd_addr;
    logic                        busy;

    modport master (
        output start_valid, funct3, rs1_data, rs2_data, rd_addr_in, flush, res_ready,
        input  start_ready, res_valid, res_data, res_rd_addr, busy
    );

    modport slave (
        input  start_valid, funct3, rs1_data, rs2_data, rd_addr_in, flush, res_ready,
        output start_ready, res_valid, res_data, res_rd_addr, busy
    );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract divide.
// Zero latency, no handshake; the caller registers hi/lo every cycle it wants a step.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic            is_div,
    input  logic [XLEN:0]   hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] m,
    output logic [XLEN:0]   hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;

    // Multiply: {hi,lo} is the product with the multiplier draining out of lo.
    // Divide: hi is the partial remainder, lo shifts the dividend out and quotient bits in.
    always_comb begin
        sum     = hi + (lo[0] ? {1'b0, m} : '0);
        shifted = {hi[XLEN-1:0], lo[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, m};
        if (is_div) begin
            if (!diff[XLEN+1]) begin
                hi_next = diff[XLEN:0];
                lo_next = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_next = shifted;
                lo_next = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_next = {1'b0, sum[XLEN:1]};
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 35 edges accept-to-result (3 for div-by-zero/overflow).
// Refuses new work until the result is taken; res_* hold while res_ready is low.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    import muldiv_pkg::*;

    muldiv_state_e   state;
    muldiv_op_e      op;
    logic [XLEN-1:0] a_raw, b_raw, m, lo, res_data;
    logic [XLEN:0]   hi;
    logic [5:0]      cnt;
    logic [4:0]      rd, res_rd;
    logic            neg_res, neg_rem;

    logic            a_neg, b_neg, div0, ovf;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   hi_next;
    logic [XLEN-1:0] lo_next;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, result;

    always_comb begin
        a_neg = op_a_signed(op) && a_raw[XLEN-1];
        b_neg = op_b_signed(op) && b_raw[XLEN-1];
        a_mag = a_neg ? -a_raw : a_raw;
        b_mag = b_neg ? -b_raw : b_raw;
        div0  = op_is_div(op) && (b_raw == '0);
        ovf   = (op == OP_DIV || op == OP_REM) && (a_raw == OVF_QUOT) && (b_raw == DIV0_QUOT);
    end

    muldiv_step u_step (
        .is_div  (op_is_div(op)),
        .hi      (hi),
        .lo      (lo),
        .m       (m),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    // Special-case results are loaded with neg_* cleared so FIX passes them through untouched.
    always_comb begin
        prod     = {hi[XLEN-1:0], lo};
        prod_fix = neg_res ? -prod : prod;
        quo_fix  = neg_res ? -lo : lo;
        rem_fix  = neg_rem ? -hi[XLEN-1:0] : hi[XLEN-1:0];
        case (op)
            OP_MUL:                      result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             result = quo_fix;
            default:                     result = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            op       <= OP_MUL;
            a_raw    <= '0;
            b_raw    <= '0;
            m        <= '0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            rd       <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            res_data <= '0;
            res_rd   <= '0;
        end else if (bus.flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start_valid) begin
                        op    <= muldiv_op_e'(bus.funct3);
                        a_raw <= bus.rs1_data;
                        b_raw <= bus.rs2_data;
                        rd    <= bus.rd_addr_in;
                        state <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    cnt <= '0;
                    if (div0) begin
                        hi      <= {1'b0, a_raw};
                        lo      <= DIV0_QUOT;
                        neg_res <= 1'b0;
                        neg_rem <= 1'b0;
                        state   <= ST_FIX;
                    end else if (ovf) begin
                        hi      <= '0;
                        lo      <= OVF_QUOT;
                        neg_res <= 1'b0;
                        neg_rem <= 1'b0;
                        state   <= ST_FIX;
                    end else begin
                        hi      <= '0;
                        lo      <= op_is_div(op) ? a_mag : b_mag;
                        m       <= op_is_div(op) ? b_mag : a_mag;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    hi  <= hi_next;
                    lo  <= lo_next;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    res_data <= result;
                    res_rd   <= rd;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.start_ready = (state == ST_IDLE);
    assign bus.busy        = (state != ST_IDLE);
    assign bus.res_valid   = (state == ST_DONE);
    assign bus.res_data    = res_data;
    assign bus.res_rd_addr = res_rd;

endmodule
